// File: rtl/shift_reg_if.sv
// Control/data bundle for the rotating shift register: enable and direction
// in, register contents out. Clock and reset stay as plain ports on the block.
interface shift_reg_if #(
  parameter int N_BITS = 4
);
  logic              i_enable;
  logic              i_selector;
  logic [N_BITS-1:0] o_shift;

  // Source of enable/direction, consumer of the pattern (e.g. tick logic).
  modport master (
    output i_enable,
    output i_selector,
    input  o_shift
  );

  // The shift register itself.
  modport slave (
    input  i_enable,
    input  i_selector,
    output o_shift
  );
endinterface : shift_reg_if

// File: rtl/shift_reg.sv
// Registered N-bit rotating shift register with a clock-enable prescaler.
// Each PRESCALE enabled cycles the contents rotate one position, left
// (toward MSB) when i_selector=0 or right (toward LSB) when i_selector=1.
// Rotation preserves population count, so a nonzero SEED never decays to 0.
module shift_reg #(
  parameter int                N_BITS   = 4,
  parameter logic [N_BITS-1:0] SEED     = N_BITS'(1),
  parameter int                PRESCALE = 1
) (
  input  logic       clock,
  input  logic       i_reset,
  shift_reg_if.slave bus
);

  // Counter must still exist as one bit when PRESCALE is 1.
  localparam int               CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]  count_q;
  logic [N_BITS-1:0] shift_q;
  logic [N_BITS-1:0] shift_rot;
  logic              step;

  // A step happens on the enabled cycle that closes a prescale period.
  always_comb begin
    step = bus.i_enable && (count_q == CNT_MAX);
  end

  // Current contents rotated by one in the direction sampled this edge.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // signal unassigned; an unassigned path would infer a latch.
    shift_rot = shift_q;
    if (bus.i_selector) begin
      shift_rot = {shift_q[0], shift_q[N_BITS-1:1]};
    end else begin
      shift_rot = {shift_q[N_BITS-2:0], shift_q[N_BITS-1]};
    end
  end

  // Prescaler: counts enabled cycles, wraps to zero on each step.
  // Direction changes deliberately do not touch it.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (i_reset) begin
      count_q <= '0;
    end else if (bus.i_enable) begin
      count_q <= step ? '0 : count_q + CNT_W'(1);
    end
  end

  // Pattern register: reset reloads SEED with priority over everything.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      shift_q <= SEED;
    end else if (step) begin
      shift_q <= shift_rot;
    end
  end

  // Output comes straight from the flops; no input-to-output comb path.
  assign bus.o_shift = shift_q;

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg. Two instances share clock and stimulus:
// dut_a with PRESCALE=1 and dut_b with PRESCALE=3. A reference model computes
// the expected pattern for each as stimulus is driven and pushes it to a
// per-instance queue; the entries are popped and compared after the edge.
module tb_shift_reg;

  localparam int N = 4;

  logic clock = 1'b0;
  logic i_reset;

  always #5 clock = ~clock;

  shift_reg_if #(.N_BITS(N)) bus_a ();
  shift_reg_if #(.N_BITS(N)) bus_b ();

  shift_reg #(.N_BITS(N), .SEED(4'b0001), .PRESCALE(1)) dut_a (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus_a)
  );

  shift_reg #(.N_BITS(N), .SEED(4'b0001), .PRESCALE(3)) dut_b (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] q_a[$];
  logic [N-1:0] q_b[$];

  // Reference state
  logic [N-1:0] m_a, m_b;
  int           c_a, c_b;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] rot(input logic [N-1:0] v, input logic sel);
    logic [N-1:0] r;
    if (sel) r = (v >> 1) | (v << (N - 1));
    else     r = (v << 1) | (v >> (N - 1));
    return r;
  endfunction

  // One clock cycle: drive inputs, advance the model, push expectations,
  // then pop and compare after the rising edge.
  task automatic cyc(input logic rst, input logic en, input logic sel, input string tag);
    logic [N-1:0] exp;
    @(negedge clock);
    i_reset          = rst;
    bus_a.i_enable   = en;
    bus_a.i_selector = sel;
    bus_b.i_enable   = en;
    bus_b.i_selector = sel;
    if (rst) begin
      m_a = 4'b0001; c_a = 0;
      m_b = 4'b0001; c_b = 0;
    end else if (en) begin
      if (c_a == 0) m_a = rot(m_a, sel);
      else          c_a = c_a + 1;
      if (c_b == 2) begin c_b = 0; m_b = rot(m_b, sel); end
      else          c_b = c_b + 1;
    end
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    @(posedge clock);
    #1;
    if (q_a.size() == 0) check({tag, "_a_empty"}, bus_a.o_shift, 'x);
    else begin exp = q_a.pop_front(); check({tag, "_a"}, bus_a.o_shift, exp); end
    if (q_b.size() == 0) check({tag, "_b_empty"}, bus_b.o_shift, 'x);
    else begin exp = q_b.pop_front(); check({tag, "_b"}, bus_b.o_shift, exp); end
  endtask

  initial begin
    logic [N-1:0] plan[];
    i_reset = 1'b0;
    bus_a.i_enable = 1'b0; bus_a.i_selector = 1'b0;
    bus_b.i_enable = 1'b0; bus_b.i_selector = 1'b0;
    m_a = '0; m_b = '0; c_a = 0; c_b = 0;

    // Reset held for 3 edges with enable toggling, then idle with enable low.
    cyc(1'b1, 1'b1, 1'b0, "rst_hold");
    check("rst_seed0", bus_a.o_shift, 4'b0001);
    cyc(1'b1, 1'b0, 1'b1, "rst_hold");
    cyc(1'b1, 1'b1, 1'b1, "rst_hold");
    check("rst_seed2", bus_a.o_shift, 4'b0001);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, "idle");
    check("idle_hold", bus_a.o_shift, 4'b0001);

    // Left rotate, 5 consecutive enabled edges.
    plan = new[5];
    plan = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, "left");
      check("left_plan", bus_a.o_shift, plan[i]);
    end

    // Right rotate with enable high on alternate edges, from SEED.
    cyc(1'b1, 1'b0, 1'b0, "rst");
    for (int i = 0; i < 8; i++) cyc(1'b0, (i % 2 == 0), 1'b1, "right_gap");
    check("right_gap_end", bus_a.o_shift, 4'b0001);

    // Direction change mid-sequence: left to 0100, then right.
    cyc(1'b1, 1'b0, 1'b0, "rst");
    cyc(1'b0, 1'b1, 1'b0, "dir_left");
    cyc(1'b0, 1'b1, 1'b0, "dir_left");
    check("dir_at_0100", bus_a.o_shift, 4'b0100);
    plan = '{4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, "dir_right");
      check("dir_plan", bus_a.o_shift, plan[i]);
    end

    // Reset mid-operation from 1000 with enable high, then one left step.
    cyc(1'b1, 1'b1, 1'b0, "mid_rst");
    check("mid_rst_seed", bus_a.o_shift, 4'b0001);
    cyc(1'b0, 1'b1, 1'b0, "after_rst");
    check("after_rst_left", bus_a.o_shift, 4'b0010);

    // Prescale=3: continuous enable, selector toggles only between steps.
    cyc(1'b1, 1'b0, 1'b0, "rst");
    plan = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
             4'b0100, 4'b0100, 4'b0100, 4'b1000};
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, (i % 3 == 2) ? 1'b0 : logic'(i % 2), "presc");
      check("presc_plan", bus_b.o_shift, plan[i]);
    end

    // Random mix with occasional reset; model tracks both instances.
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), "rand");
      check("rand_onehot_a", 4'($countones(bus_a.o_shift)), 4'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_shift_reg
